img2col_window_ctrl: RTL

- Upstream sequencer for the img2col window register file.
- Walks a K×K sliding window (stride 1) over an IMG_H×IMG_W feature map held in a synchronous-read buffer.
- Fetches one pixel per cycle and writes it into the register file by address (row-major within the window), then issues the parallel-read command.
- Presents each completed window to the downstream consumer with a valid/ready handshake.

---
 rtl/img2col_window_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/img2col_window_ctrl.sv
// Sequencer that walks a KxK stride-1 window over a feature-map buffer.
// It fills the img2col register file one pixel per cycle and hands each window downstream.
module img2col_window_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 5,
    parameter int RF_AW      = 5,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int FM_AW      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       fm_rd_en,
    output logic [FM_AW-1:0]           fm_addr,
    input  logic [DATA_WIDTH-1:0]      fm_rdata,
    output logic                       rf_wr_ctrl,
    output logic [RF_AW-1:0]           rf_adrs,
    output logic [DATA_WIDTH-1:0]      rf_din,
    output logic                       rf_r_ctrl,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int KW    = (K > 1) ? $clog2(K) : 1;

    localparam logic [RF_AW-1:0] LAST_ELEM = RF_AW'(K*K - 1);
    localparam logic [KW-1:0]    K_MAX     = KW'(K - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - K);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_LATCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [RF_AW-1:0] elem_n;
    logic [KW-1:0]    elem_r;
    logic [KW-1:0]    elem_c;

    logic accept;
    logic handshake;
    logic last_win;

    assign accept    = (state == S_IDLE) && start;
    assign handshake = (state == S_PRESENT) && win_ready;
    assign last_win  = (win_row == ROW_MAX) && (win_col == COL_MAX);

    // State register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (start) state_nxt = S_FETCH;
            S_FETCH:   if (elem_n == LAST_ELEM) state_nxt = S_DRAIN;
            S_DRAIN:   state_nxt = S_LATCH;
            S_LATCH:   state_nxt = S_PRESENT;
            S_PRESENT: if (win_ready) state_nxt = last_win ? S_DONE : S_FETCH;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Element counter: n counts linearly, while (elem_r, elem_c) track n/K and n%K without a divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_n <= '0;
            elem_r <= '0;
            elem_c <= '0;
        end else if (accept || handshake) begin
            elem_n <= '0;
            elem_r <= '0;
            elem_c <= '0;
        end else if (state == S_FETCH && elem_n != LAST_ELEM) begin
            elem_n <= elem_n + 1'b1;
            if (elem_c == K_MAX) begin
                elem_c <= '0;
                elem_r <= elem_r + 1'b1;
            end else begin
                elem_c <= elem_c + 1'b1;
            end
        end
    end

    // Window origin advances raster-order on every non-final handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row <= '0;
            win_col <= '0;
        end else if (accept) begin
            win_row <= '0;
            win_col <= '0;
        end else if (handshake && !last_win) begin
            if (win_col == COL_MAX) begin
                win_col <= '0;
                win_row <= win_row + 1'b1;
            end else begin
                win_col <= win_col + 1'b1;
            end
        end
    end

    logic [FM_AW-1:0] row_sum;
    logic [FM_AW-1:0] col_sum;

    assign row_sum = FM_AW'(win_row) + FM_AW'(elem_r);
    assign col_sum = FM_AW'(win_col) + FM_AW'(elem_c);

    // Output decode; the write path trails the read by one cycle to match the buffer latency.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        fm_rd_en   = 1'b0;
        fm_addr    = '0;
        rf_wr_ctrl = 1'b0;
        rf_adrs    = '0;
        rf_din     = '0;
        rf_r_ctrl  = 1'b0;
        win_valid  = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_FETCH: begin
                busy     = 1'b1;
                fm_rd_en = 1'b1;
                fm_addr  = row_sum * FM_AW'(IMG_W) + col_sum;
                if (elem_n != '0) begin
                    rf_wr_ctrl = 1'b1;
                    rf_adrs    = elem_n - 1'b1;
                    rf_din     = fm_rdata;
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                rf_wr_ctrl = 1'b1;
                rf_adrs    = LAST_ELEM;
                rf_din     = fm_rdata;
            end
            S_LATCH: begin
                busy      = 1'b1;
                rf_r_ctrl = 1'b1;
            end
            S_PRESENT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
